// File: rtl/mem_arb_pkg.sv
// Shared types for the single-port memory arbiter: FSM states and transaction owner.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory port, one transaction in flight.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_gnt,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                busy
);

  state_t            state;
  owner_t            owner;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              pick_d;
  logic              rsp_done;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_cnt;

  // Once the data side has won STARVE_MAX times over a waiting fetch, the fetch wins.
  assign pick_d = d_req && !(if_req && (starve_cnt == CNT_W'(STARVE_MAX)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (state == IDLE && (if_req || d_req)) begin
      if (!pick_d)
        starve_cnt <= '0;
      else if (if_req)
        starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_wstrb    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            state <= REQ;
            if (pick_d) begin
              owner   <= OWN_D;
              m_we    <= d_we;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              m_wstrb <= d_wstrb;
            end else begin
              owner   <= OWN_IF;
              m_we    <= 1'b0;
              m_addr  <= if_addr;
              m_wdata <= '0;
              m_wstrb <= '0;
            end
          end
        end
        // An m_rvalid arriving together with m_gnt is not a response yet.
        REQ: if (m_gnt) state <= RSP;
        RSP: begin
          if (m_rvalid) begin
            state <= IDLE;
            if (owner == OWN_D) d_rdata_q  <= m_rdata;
            else                if_rdata_q <= m_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_req     = (state == REQ);
  assign busy      = (state != IDLE);
  assign rsp_done  = (state == RSP) && m_rvalid;
  assign if_rvalid = rsp_done && (owner == OWN_IF);
  assign d_rvalid  = rsp_done && (owner == OWN_D);
  // Owner sees memory data in the response cycle; the other port keeps its last value.
  assign if_rdata  = if_rvalid ? m_rdata : if_rdata_q;
  assign d_rdata   = d_rvalid  ? m_rdata : d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level model checked every cycle plus literal pins.
module tb_mem_arbiter;
  localparam int SMAX = 4;

  logic        clk, rst_n;
  logic        if_req, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic        m_req, m_we, m_gnt, m_rvalid, busy;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
  );

  initial begin clk = 0; forever #5 clk = ~clk; end

  int total = 0, bad = 0, cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory: grants after gnt_wait REQ cycles, answers rsp_wait cycles later with addr+3.
  int gnt_wait = 0, rsp_wait = 0;
  bit spur = 0, pend = 0;
  int mcnt = 0;
  logic [31:0] rsp_data;
  initial begin
    m_gnt = 0; m_rvalid = 0; m_rdata = 0;
    forever begin
      @(posedge clk); #1;
      m_gnt = 0; m_rvalid = 0;
      if (!rst_n) begin
        pend = 0; mcnt = 0;
      end else if (spur) begin
        m_rvalid = 1; m_rdata = 32'hBAD0_0000; spur = 0;
      end else if (pend) begin
        if (mcnt >= rsp_wait) begin m_rvalid = 1; m_rdata = rsp_data; pend = 0; mcnt = 0; end
        else mcnt++;
      end else if (m_req) begin
        if (mcnt >= gnt_wait) begin m_gnt = 1; pend = 1; mcnt = 0; rsp_data = m_addr + 32'd3; end
        else mcnt++;
      end
    end
  end

  // Requesters drop their request in the cycle their response arrives (unless held).
  bit d_hold = 0;
  initial forever begin
    @(negedge clk);
    if (if_rvalid) if_req = 0;
    if (d_rvalid && !d_hold) d_req = 0;
  end

  // Model: one transaction at a time, data first, optional fetch guard.
  typedef struct { bit own_d; logic we; logic [31:0] addr, wdata; logic [3:0] strb; } txn_t;
  txn_t cur;
  bit   m_idle = 1, m_granted = 0;
  int   waits = 0;
  logic [31:0] exp_if_rd = 0, exp_d_rd = 0;
  bit   e_irv, e_drv, take_d;

  int first_req_cyc, req_cycles, if_pulses, d_pulses, if_rv_cyc, d_rv_cyc, d_before_if;
  logic first_we; logic [31:0] first_addr; logic [3:0] first_strb;

  initial forever begin
    @(negedge clk); #2;
    if (!rst_n) begin
      check("reset_outputs", {busy, m_req, m_we, if_rvalid, d_rvalid, m_addr, m_wdata, m_wstrb},
            '0);
      check("reset_rdata", {if_rdata, d_rdata}, '0);
      m_idle = 1; m_granted = 0; waits = 0; exp_if_rd = 0; exp_d_rd = 0;
    end else begin
      check("busy", busy, !m_idle);
      check("m_req", m_req, !m_idle && !m_granted);
      if (!m_idle && !m_granted)
        check("payload", {m_we, m_addr, m_wdata, m_wstrb},
              {cur.we, cur.addr, cur.wdata, cur.strb});
      e_irv = !m_idle && m_granted && m_rvalid && !cur.own_d;
      e_drv = !m_idle && m_granted && m_rvalid &&  cur.own_d;
      check("if_rvalid", if_rvalid, e_irv);
      check("d_rvalid", d_rvalid, e_drv);
      if (e_irv) exp_if_rd = m_rdata;
      if (e_drv) exp_d_rd  = m_rdata;
      check("if_rdata", if_rdata, exp_if_rd);
      check("d_rdata", d_rdata, exp_d_rd);
      if (m_req) begin
        req_cycles++;
        if (first_req_cyc < 0) begin
          first_req_cyc = cyc; first_we = m_we; first_addr = m_addr; first_strb = m_wstrb;
        end
      end
      if (if_rvalid) begin
        if (if_pulses == 0) d_before_if = d_pulses;
        if_pulses++; if_rv_cyc = cyc;
      end
      if (d_rvalid) begin d_pulses++; d_rv_cyc = cyc; end
      if (m_idle) begin
        if (if_req || d_req) begin
          take_d = d_req;
`ifdef MEM_ARB_STARVE_GUARD_EN
          if (d_req && if_req && waits == SMAX) take_d = 0;
`endif
          if (take_d) begin
            cur = '{1'b1, d_we, d_addr, d_wdata, d_wstrb};
            if (if_req) waits++;
          end else begin
            cur = '{1'b0, 1'b0, if_addr, 32'd0, 4'd0};
            waits = 0;
          end
          m_idle = 0; m_granted = 0;
        end
      end else if (!m_granted) begin
        if (m_gnt) m_granted = 1;
      end else if (m_rvalid) begin
        m_idle = 1;
      end
    end
  end

  task automatic clear_marks();
    first_req_cyc = -1; req_cycles = 0; if_pulses = 0; d_pulses = 0;
    if_rv_cyc = -1; d_rv_cyc = -1; d_before_if = -1;
  endtask

  logic busy3;
  task automatic wait_idle(input string nm, input int t0, input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk); #3;
      if (cyc == t0 + 3) busy3 = busy;
      if (!if_req && !d_req && !busy) break;
    end
    check(nm, {if_req, d_req, busy}, 3'b000);
  endtask

  int t0;
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
    clear_marks();
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // Lone fetch, zero-wait memory
    clear_marks(); busy3 = 1'bx;
    @(negedge clk); t0 = cyc; if_addr = 32'h10; if_req = 1;
    wait_idle("fetch_done", t0, 40);
    check("fetch_mreq_lat", first_req_cyc - t0, 1);
    check("fetch_strb", first_strb, 4'h0);
    check("fetch_rv_lat", if_rv_cyc - t0, 2);
    check("fetch_rdata", if_rdata, 32'h13);
    check("fetch_busy_n3", busy3, 1'b0);

    // Collision: store wins, fetch follows
    clear_marks();
    @(negedge clk); t0 = cyc;
    d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF; d_req = 1;
    if_addr = 32'h20; if_req = 1;
    wait_idle("coll_done", t0, 60);
    d_we = 0;
    check("coll_first_we", first_we, 1'b1);
    check("coll_first_addr", first_addr, 32'h100);
    check("coll_d_once", d_pulses, 1);
    check("coll_if_once", if_pulses, 1);
    check("coll_d_rv_lat", d_rv_cyc - t0, 2);
    check("coll_if_rv_lat", if_rv_cyc - t0, 5);
    check("coll_d_rdata", d_rdata, 32'h103);
    check("coll_if_rdata", if_rdata, 32'h23);

    // Wait states on a load, then a stray m_rvalid while idle
    clear_marks(); gnt_wait = 3; rsp_wait = 2;
    @(negedge clk); t0 = cyc; d_addr = 32'h40; d_req = 1;
    wait_idle("ws_done", t0, 60);
    check("ws_req_cycles", req_cycles, 4);
    check("ws_rv_lat", d_rv_cyc - t0, 7);
    check("ws_rdata", d_rdata, 32'h43);
    gnt_wait = 0; rsp_wait = 0; clear_marks();
    @(negedge clk); spur = 1;
    repeat (4) @(negedge clk);
    #3;
    check("spur_pulses", if_pulses + d_pulses, 0);
    check("spur_hold", {busy, if_rdata, d_rdata}, {1'b0, 32'h23, 32'h43});

    // Reset while awaiting the response
    clear_marks(); rsp_wait = 3;
    @(negedge clk); t0 = cyc; if_addr = 32'h80; if_req = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #3;
      if (busy && !m_req) break;
    end
    check("rst_in_rsp", {busy, m_req}, 2'b10);
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1; if_req = 0;
    repeat (6) @(negedge clk);
    #3;
    check("rst_no_pulse", if_pulses + d_pulses, 0);
    rsp_wait = 0; clear_marks();
    @(negedge clk); t0 = cyc; if_addr = 32'h90; if_req = 1;
    wait_idle("post_rst_done", t0, 40);
    check("post_rst_pulse", if_pulses, 1);
    check("post_rst_rdata", if_rdata, 32'h93);

    // Continuous data traffic against a waiting fetch
    clear_marks();
    @(negedge clk); t0 = cyc;
    d_hold = 1; d_we = 0; d_addr = 32'h200; d_req = 1; if_addr = 32'h300; if_req = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #3;
      if (if_pulses > 0 || d_pulses >= 8) break;
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    check("starve_d_before_if", d_before_if, SMAX);
    check("starve_if_rdata", if_rdata, 32'h303);
`else
    check("strict_no_fetch", if_pulses, 0);
    check("strict_d_count", d_pulses, 8);
`endif
    @(negedge clk); d_hold = 0; d_req = 0;
    wait_idle("starve_done", t0, 100);
    check("starve_fetch_served", if_pulses, 1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 32, data width; the strobe width is DATA_W/8.
REQ-003 Parameter STARVE_MAX, default 4, maximum consecutive data grants while a fetch waits (used only under REQ-024).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 if_req  input  1  fetch request, held high until if_rvalid.
REQ-007 if_addr  input  ADDR_W  fetch address.
REQ-008 if_rvalid  output  1  one-cycle pulse, fetch data valid.
REQ-009 if_rdata  output  DATA_W  fetch read data.
REQ-010 d_req  input  1  data request, held high until d_rvalid.
REQ-011 d_we / d_addr / d_wdata / d_wstrb  input  1/ADDR_W/DATA_W/DATA_W/8  data write enable, address, write data and byte strobes.
REQ-012 d_rvalid  output  1  one-cycle pulse, data access complete (load data or store acknowledge).
REQ-013 d_rdata  output  DATA_W  load data.
REQ-014 m_req / m_we / m_addr / m_wdata / m_wstrb  output  1/1/ADDR_W/DATA_W/DATA_W/8  single shared memory-port request.
REQ-015 m_gnt  input  1  memory accepted request.
REQ-016 m_rvalid / m_rdata  input  1/DATA_W  memory response; every accepted request, read or write, returns exactly one m_rvalid.
REQ-017 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-018 The FSM SHALL have three states: IDLE, REQ and RSP; at most one transaction SHALL be outstanding.
REQ-019 In IDLE, when any request is high, the arbiter SHALL latch the winner's address, write data, strobe, write enable and owner ID, then enter REQ on the next edge.
- Default priority is d_req over if_req.
- A fetch is a read with m_wstrb=0.
REQ-020 In REQ, m_req SHALL be high with registered payload stable; on m_gnt=1 it enters RSP the next edge; m_req low in IDLE and RSP.
REQ-021 In RSP, on m_rvalid=1 the arbiter SHALL drive m_rdata combinationally to the owner's rdata, pulse only the owner's rvalid that cycle, and return to IDLE.
REQ-022 Latency SHALL be as follows:
- Request visible at cycle N gives m_req at N+1.
- Zero-wait memory (m_gnt at N+1, m_rvalid at N+2) gives owner rvalid at N+2.
- The next arbitration occurs in the IDLE cycle N+3.
REQ-023 Boundary conditions:
- Requester deassertion after latch SHALL NOT abort the transaction.
- m_rvalid outside RSP SHALL be ignored.
- Simultaneous m_gnt and m_rvalid in REQ SHALL be treated as gnt only.
- Non-owner rdata outputs hold their last value.

Reset
REQ-025 While rst_n=0:
- The FSM SHALL be IDLE.
- m_req, m_we, if_rvalid, d_rvalid and busy SHALL be 0.
- m_addr, m_wdata, m_wstrb, if_rdata, d_rdata and the starvation counter SHALL be 0.
- Reset asserted mid-transaction SHALL drop the transaction without an rvalid pulse.

Configuration
REQ-024 Macro MEM_ARB_STARVE_GUARD_EN.
- Defined: a counter SHALL increment on each data grant made while if_req=1 and clear on any fetch grant. When it equals STARVE_MAX, the next arbitration with if_req=1 SHALL grant fetch.
- Undefined: strict data priority; no counter is instantiated.

Structure
REQ-026 The shared package mem_arb_pkg SHALL hold the state enum (IDLE/REQ/RSP) and the owner enum (OWN_IF/OWN_D).
REQ-027 The module SHALL be flat with no sub-module; the starvation counter is inline, guarded by the macro.

Verification
REQ-028 Lone fetch: if_req=1, if_addr=0x0000_0010, memory with 0-wait gnt and rvalid next cycle, m_rdata=0x0000_0013 -> m_req at N+1 with m_wstrb=0; if_rvalid=1 with if_rdata=0x13 at N+2; busy low at N+3.
REQ-029 Collision: if_req and d_req together, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_wstrb=0xF -> the data store is issued first with m_we=1; d_rvalid pulses; the fetch is then issued and if_rvalid pulses; both pulse exactly once.
REQ-030 Wait states: m_gnt delayed 3 cycles, m_rvalid delayed 2 more -> m_req and payload stable for all 4 REQ cycles; no rvalid pulse before m_rvalid; a spurious m_rvalid in IDLE has no effect.
REQ-031 Reset mid-RSP: rst_n=0 for one cycle while awaiting m_rvalid -> all outputs at reset values, no rvalid pulse, and a later request proceeds normally.
REQ-032 Starvation (macro defined, STARVE_MAX=4): d_req held continuously with if_req=1 -> the fetch is granted after exactly 4 data transactions. With the macro undefined, the fetch is never granted while d_req=1.
